// File: rtl/pc_seq_pkg.sv
// ---------------------------------------------------------------------------
// pc_seq_pkg
//   Shared definitions for the program-counter sequencer:
//     seq_state_e  - sequencer state encoding (BOOT, RUN, HALT)
//     PC_STEP      - sequential fetch increment
//     ALIGN_MASK   - clears the two low bits of a word-aligned fetch address
//     is_misaligned() - true when an address is not word aligned
// ---------------------------------------------------------------------------
package pc_seq_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } seq_state_e;

    localparam logic [31:0] PC_STEP    = 32'd4;
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/pc_sequencer_fa32.sv
// ---------------------------------------------------------------------------
// pc_sequencer_fa32
//   32-bit full adder used to form the link value pc_out + 4.
//   Unsigned, wraps modulo 2^32; carry out is not needed by the sequencer.
// Ports:
//   a    in  32  first operand
//   b    in  32  second operand
//   sum  out 32  a + b (mod 2^32)
// ---------------------------------------------------------------------------
module pc_sequencer_fa32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);

    // Plain unsigned add; the wrap from 0xFFFF_FFFC + 4 to 0 falls out naturally.
    assign sum = a + b;

endmodule

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//   Program-counter register and next-PC sequencer. Chooses between jump,
//   branch, a buffered (pending) redirect and the sequential pc_out + 4, and
//   presents pc_out to instruction memory over a valid/ready handshake.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   - a misaligned redirect target loads TRAP_VEC, pulses misalign
//               and records the faulting target in misalign_epc.
//   undefined - redirect targets have bits [1:0] forced to zero; misalign and
//               misalign_epc are tied to zero.
//
// Parameters:
//   TRAP_VEC   trap target for misaligned redirects (MISALIGN_TRAP_EN only)
//   RESET_VEC  pc_out value after reset
//
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   branch_add     branch target          branch_taken  branch taken
//   jump_add       jump target            jump_en       jump
//   halt_req       current instruction is a halt
//   stall          datapath cannot take a new instruction
//   imem_ready     instruction memory accepts pc_out
//   pc_out         current fetch address  pc_plus4      pc_out + 4
//   fetch_valid    fetch request valid    halted        sequencer in HALT
//   misalign       one-cycle trap pulse   misalign_epc  faulting target
// ---------------------------------------------------------------------------
module pc_sequencer
    import pc_seq_pkg::*;
#(
`ifdef MISALIGN_TRAP_EN
    parameter logic [31:0] TRAP_VEC  = 32'h0000_0100,
`endif
    parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] branch_add,
    input  logic        branch_taken,
    input  logic [31:0] jump_add,
    input  logic        jump_en,
    input  logic        halt_req,
    input  logic        stall,
    input  logic        imem_ready,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid,
    output logic        halted,
    output logic        misalign,
    output logic [31:0] misalign_epc
);

    seq_state_e  state;
    seq_state_e  state_next;
    logic        pend_v;
    logic [31:0] pend_tgt;
    logic        accept;
    logic        redirect_now;
    logic [31:0] redirect_tgt;
    logic [31:0] next_pc;
    logic        trap_hit;

    pc_sequencer_fa32 u_fa32 (
        .a   (pc_out),
        .b   (PC_STEP),
        .sum (pc_plus4)
    );

    assign fetch_valid  = (state == RUN);
    assign halted       = (state == HALT);
    assign accept       = fetch_valid & imem_ready & ~stall;
    assign redirect_now = jump_en | branch_taken;

    // Next-state logic. BOOT always spends exactly one cycle before fetching;
    // HALT is sticky and only reset leaves it.
    always_comb begin
        state_next = state;
        case (state)
            BOOT:    state_next = RUN;
            RUN:     if (accept && halt_req) state_next = HALT;
            HALT:    state_next = HALT;
            default: state_next = BOOT;
        endcase
    end

    // Next-PC select with priority jump > branch > pending > sequential.
    // Without the trap feature the redirect target is forced to word
    // alignment before it is used or buffered, so pc_out can never go odd.
    always_comb begin
        redirect_tgt = jump_en ? jump_add : branch_add;
`ifndef MISALIGN_TRAP_EN
        redirect_tgt = redirect_tgt & ALIGN_MASK;
`endif
        next_pc = pc_plus4;
        if (redirect_now) begin
            next_pc = redirect_tgt;
        end else if (pend_v) begin
            next_pc = pend_tgt;
        end
`ifdef MISALIGN_TRAP_EN
        trap_hit = is_misaligned(next_pc);
`else
        trap_hit = 1'b0;
`endif
    end

    // PC register, FSM state and the pending-redirect buffer. A redirect seen
    // while the fetch is held off is remembered so it is not lost; a halt at
    // accept freezes pc_out and throws any buffered redirect away.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= BOOT;
            pc_out   <= RESET_VEC;
            pend_v   <= 1'b0;
            pend_tgt <= 32'h0;
        end else begin
            state <= state_next;
            if (accept) begin
                pend_v <= 1'b0;
                if (!halt_req) begin
`ifdef MISALIGN_TRAP_EN
                    pc_out <= trap_hit ? TRAP_VEC : next_pc;
`else
                    pc_out <= next_pc;
`endif
                end
            end else if (fetch_valid && redirect_now) begin
                pend_v   <= 1'b1;
                pend_tgt <= redirect_tgt;
            end
        end
    end

`ifdef MISALIGN_TRAP_EN
    // Trap reporting: misalign pulses for the cycle after the faulting accept,
    // misalign_epc keeps the offending target until the next trap.
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign     <= 1'b0;
            misalign_epc <= 32'h0;
        end else begin
            misalign <= 1'b0;
            if (accept && !halt_req && trap_hit) begin
                misalign     <= 1'b1;
                misalign_epc <= next_pc;
            end
        end
    end
`else
    assign misalign     = 1'b0;
    assign misalign_epc = 32'h0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
//   Directed self-checking bench for pc_sequencer. Inputs change and outputs
//   are observed 1ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] branch_add;
    logic        branch_taken;
    logic [31:0] jump_add;
    logic        jump_en;
    logic        halt_req;
    logic        stall;
    logic        imem_ready;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        halted;
    logic        misalign;
    logic [31:0] misalign_epc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .branch_add   (branch_add),
        .branch_taken (branch_taken),
        .jump_add     (jump_add),
        .jump_en      (jump_en),
        .halt_req     (halt_req),
        .stall        (stall),
        .imem_ready   (imem_ready),
        .pc_out       (pc_out),
        .pc_plus4     (pc_plus4),
        .fetch_valid  (fetch_valid),
        .halted       (halted),
        .misalign     (misalign),
        .misalign_epc (misalign_epc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        branch_taken = 1'b0;
        jump_en      = 1'b0;
        halt_req     = 1'b0;
        stall        = 1'b0;
        imem_ready   = 1'b1;
        branch_add   = 32'h0;
        jump_add     = 32'h0;
    endtask

    task automatic jump_to(input logic [31:0] tgt);
        jump_en  = 1'b1;
        jump_add = tgt;
        tick();
        jump_en  = 1'b0;
    endtask

    task automatic test_reset();
        clear_ctrl();
        rst = 1'b1;
        tick();
        total++; if (pc_out !== 32'h0) begin bad++; $display("[TB] FAIL reset_pc: got %h want %h", pc_out, 32'h0); end
        total++; if (fetch_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_fv: got %b want 0", fetch_valid); end
        total++; if (halted !== 1'b0) begin bad++; $display("[TB] FAIL reset_halted: got %b want 0", halted); end
        total++; if (misalign !== 1'b0 || misalign_epc !== 32'h0) begin bad++; $display("[TB] FAIL reset_misalign: got %b/%h want 0/0", misalign, misalign_epc); end
        rst = 1'b0;
        tick();
        total++; if (fetch_valid !== 1'b1 || pc_out !== 32'h0) begin bad++; $display("[TB] FAIL boot_exit: got fv=%b pc=%h want 1/0", fetch_valid, pc_out); end
        total++; if (pc_plus4 !== 32'h4) begin bad++; $display("[TB] FAIL pc_plus4: got %h want 4", pc_plus4); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_seq [3];
        exp_seq[0] = 32'h4; exp_seq[1] = 32'h8; exp_seq[2] = 32'hC;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (pc_out !== exp_seq[i]) begin bad++; $display("[TB] FAIL seq_%0d: got %h want %h", i, pc_out, exp_seq[i]); end
        end
        tick();
        total++; if (pc_out !== 32'h10) begin bad++; $display("[TB] FAIL seq_10: got %h want 10", pc_out); end
    endtask

    task automatic test_branch_jump();
        branch_taken = 1'b1; branch_add = 32'h40;
        tick();
        branch_taken = 1'b0;
        total++; if (pc_out !== 32'h40) begin bad++; $display("[TB] FAIL branch: got %h want 40", pc_out); end
        jump_en = 1'b1; jump_add = 32'h80; branch_taken = 1'b1; branch_add = 32'h44;
        tick();
        clear_ctrl();
        total++; if (pc_out !== 32'h80) begin bad++; $display("[TB] FAIL jump_over_branch: got %h want 80", pc_out); end
        total++; if (pc_plus4 !== 32'h84) begin bad++; $display("[TB] FAIL plus4_after_jump: got %h want 84", pc_plus4); end
    endtask

    task automatic test_stall_pending();
        jump_to(32'h20);
        total++; if (pc_out !== 32'h20) begin bad++; $display("[TB] FAIL stall_setup: got %h want 20", pc_out); end
        stall = 1'b1; jump_en = 1'b1; jump_add = 32'h200;
        tick();
        jump_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++; if (pc_out !== 32'h20) begin bad++; $display("[TB] FAIL stall_hold_%0d: got %h want 20", i, pc_out); end
            tick();
        end
        stall = 1'b0;
        tick();
        total++; if (pc_out !== 32'h200) begin bad++; $display("[TB] FAIL pending_apply: got %h want 200", pc_out); end
        tick();
        total++; if (pc_out !== 32'h204) begin bad++; $display("[TB] FAIL pending_cleared: got %h want 204", pc_out); end
        // Two captures while memory is not ready: the later one wins.
        imem_ready = 1'b0; branch_taken = 1'b1; branch_add = 32'h300;
        tick();
        branch_add = 32'h400;
        tick();
        branch_taken = 1'b0;
        total++; if (pc_out !== 32'h204) begin bad++; $display("[TB] FAIL notready_hold: got %h want 204", pc_out); end
        imem_ready = 1'b1;
        tick();
        total++; if (pc_out !== 32'h400) begin bad++; $display("[TB] FAIL pending_overwrite: got %h want 400", pc_out); end
        // A live redirect at accept beats the buffered one.
        stall = 1'b1; jump_en = 1'b1; jump_add = 32'h500;
        tick();
        stall = 1'b0; jump_add = 32'h600;
        tick();
        jump_en = 1'b0;
        total++; if (pc_out !== 32'h600) begin bad++; $display("[TB] FAIL live_over_pending: got %h want 600", pc_out); end
        tick();
        total++; if (pc_out !== 32'h604) begin bad++; $display("[TB] FAIL live_clears_pending: got %h want 604", pc_out); end
    endtask

    task automatic test_wrap();
        jump_to(32'hFFFF_FFFC);
        total++; if (pc_plus4 !== 32'h0) begin bad++; $display("[TB] FAIL wrap_plus4: got %h want 0", pc_plus4); end
        tick();
        total++; if (pc_out !== 32'h0) begin bad++; $display("[TB] FAIL wrap_pc: got %h want 0", pc_out); end
    endtask

    task automatic test_halt_and_reset();
        jump_to(32'h30);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        total++; if (halted !== 1'b1 || fetch_valid !== 1'b0) begin bad++; $display("[TB] FAIL halt_state: got h=%b fv=%b want 1/0", halted, fetch_valid); end
        total++; if (pc_out !== 32'h30) begin bad++; $display("[TB] FAIL halt_pc: got %h want 30", pc_out); end
        jump_en = 1'b1; jump_add = 32'h700;
        tick(); tick();
        jump_en = 1'b0;
        total++; if (pc_out !== 32'h30 || halted !== 1'b1) begin bad++; $display("[TB] FAIL halt_sticky: got pc=%h h=%b want 30/1", pc_out, halted); end
        // Leave HALT, then reset while a redirect is buffered.
        rst = 1'b1; tick(); rst = 1'b0; tick();
        stall = 1'b1; jump_en = 1'b1; jump_add = 32'h500;
        tick();
        jump_en = 1'b0; rst = 1'b1;
        tick();
        total++; if (pc_out !== 32'h0 || fetch_valid !== 1'b0 || halted !== 1'b0) begin bad++; $display("[TB] FAIL midreset: got pc=%h fv=%b h=%b want 0/0/0", pc_out, fetch_valid, halted); end
        rst = 1'b0; stall = 1'b0;
        tick();
        tick();
        total++; if (pc_out !== 32'h4) begin bad++; $display("[TB] FAIL midreset_pend_dropped: got %h want 4", pc_out); end
    endtask

    task automatic test_misalign();
        jump_to(32'h10);
        branch_taken = 1'b1; branch_add = 32'h42;
        tick();
        branch_taken = 1'b0;
`ifdef MISALIGN_TRAP_EN
        total++; if (pc_out !== 32'h100) begin bad++; $display("[TB] FAIL trap_pc: got %h want 100", pc_out); end
        total++; if (misalign !== 1'b1 || misalign_epc !== 32'h42) begin bad++; $display("[TB] FAIL trap_flag: got %b/%h want 1/42", misalign, misalign_epc); end
        tick();
        total++; if (misalign !== 1'b0 || misalign_epc !== 32'h42 || pc_out !== 32'h104) begin bad++; $display("[TB] FAIL trap_after: got %b/%h pc=%h want 0/42/104", misalign, misalign_epc, pc_out); end
`else
        total++; if (pc_out !== 32'h40) begin bad++; $display("[TB] FAIL align_branch: got %h want 40", pc_out); end
        total++; if (misalign !== 1'b0 || misalign_epc !== 32'h0) begin bad++; $display("[TB] FAIL align_flag: got %b/%h want 0/0", misalign, misalign_epc); end
        jump_to(32'h83);
        total++; if (pc_out !== 32'h80) begin bad++; $display("[TB] FAIL align_jump: got %h want 80", pc_out); end
`endif
    endtask

    initial begin
        rst = 1'b1;
        clear_ctrl();
        test_reset();
        test_sequential();
        test_branch_jump();
        test_stall_pending();
        test_wrap();
        test_halt_and_reset();
        test_misalign();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
